// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types for the rv32 control sequencer and its decoder.
//   inst_type     - coarse instruction class derived from the opcode
//   fop_t         - ALU function select
//   b_t           - branch/jump kind (B_NONE for straight-line instructions)
//   ctrl_bundle_t - packed pipeline control bundle
//   seq_state_t   - sequencer FSM states
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        IT_R, IT_I, IT_LOAD, IT_STORE, IT_BRANCH,
        IT_LUI, IT_AUIPC, IT_JAL, IT_JALR, IT_BAD
    } inst_type;

    typedef enum logic [3:0] {
        FOP_ADD = 4'd0, FOP_SUB = 4'd1, FOP_SLL = 4'd2, FOP_SLT = 4'd3,
        FOP_XOR = 4'd4, FOP_SRL = 4'd5, FOP_SRA = 4'd6, FOP_OR  = 4'd7,
        FOP_AND = 4'd8, FOP_LUI = 4'd9
    } fop_t;

    typedef enum logic [2:0] {
        B_NONE = 3'd0, B_BEQ = 3'd1, B_BNE = 3'd2, B_BLT = 3'd3,
        B_BGE  = 3'd4, B_BLTU = 3'd5, B_BGEU = 3'd6, B_JUMP = 3'd7
    } b_t;

    typedef struct packed {
        fop_t alu_op;
        b_t   branch_type;
        logic reg_write_en;
        logic alu_mux_en;
        logic store_byte;
        logic load_byte;
        logic mem_to_reg;
        logic pc_add_write_value;
        logic read_next_pc;
        logic write_mem;
        logic read_mem;
        logic slt;
        logic u;
    } ctrl_bundle_t;

    typedef enum logic [1:0] {RUN, MEM_WAIT, RESOLVE, TRAP} seq_state_t;

    function automatic inst_type classify(input logic [6:0] opcode);
        case (opcode)
            OP_R:      return IT_R;
            OP_LOAD:   return IT_LOAD;
            OP_IMM:    return IT_I;
            OP_STORE:  return IT_STORE;
            OP_LUI:    return IT_LUI;
            OP_AUIPC:  return IT_AUIPC;
            OP_BRANCH: return IT_BRANCH;
            OP_JAL:    return IT_JAL;
            OP_JALR:   return IT_JALR;
            default:   return IT_BAD;
        endcase
    endfunction

endpackage

// File: rtl/control_decode.sv
// control_decode: combinational RV32I decoder.
//   key     in  17  {funct7, funct3, opcode}
//   bundle  out     decoded ctrl_bundle_t (all zero when illegal)
//   illegal out 1   key is not a supported instruction
module control_decode
    import ctrl_pkg::*;
(
    input  logic [16:0]  key,
    output ctrl_bundle_t bundle,
    output logic         illegal
);

    logic [6:0]   funct7;
    logic [2:0]   funct3;
    inst_type     itype;
    ctrl_bundle_t dec;
    logic         bad;

    assign funct7 = key[16:10];
    assign funct3 = key[9:7];
    assign itype  = classify(key[6:0]);

    always_comb begin
        dec = '0;
        bad = 1'b0;
        case (itype)
            IT_R: begin
                dec.reg_write_en = 1'b1;
                case (funct3)
                    3'b000: dec.alu_op = (funct7 == F7_ALT) ? FOP_SUB : FOP_ADD;
                    3'b001: dec.alu_op = FOP_SLL;
                    3'b010: begin dec.alu_op = FOP_SLT; dec.slt = 1'b1; end
                    3'b011: begin dec.alu_op = FOP_SLT; dec.slt = 1'b1; dec.u = 1'b1; end
                    3'b100: dec.alu_op = FOP_XOR;
                    3'b101: dec.alu_op = (funct7 == F7_ALT) ? FOP_SRA : FOP_SRL;
                    3'b110: dec.alu_op = FOP_OR;
                    3'b111: dec.alu_op = FOP_AND;
                endcase
                // Only sub and sra use the alternate funct7.
                bad = !(funct7 == F7_BASE ||
                        (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            IT_I: begin
                dec.reg_write_en = 1'b1;
                dec.alu_mux_en   = 1'b1;
                case (funct3)
                    3'b000: dec.alu_op = FOP_ADD;
                    3'b001: begin dec.alu_op = FOP_SLL; bad = (funct7 != F7_BASE); end
                    3'b010: begin dec.alu_op = FOP_SLT; dec.slt = 1'b1; end
                    3'b011: begin dec.alu_op = FOP_SLT; dec.slt = 1'b1; dec.u = 1'b1; end
                    3'b100: dec.alu_op = FOP_XOR;
                    3'b101: begin
                        dec.alu_op = (funct7 == F7_ALT) ? FOP_SRA : FOP_SRL;
                        bad = !(funct7 == F7_BASE || funct7 == F7_ALT);
                    end
                    3'b110: dec.alu_op = FOP_OR;
                    3'b111: dec.alu_op = FOP_AND;
                endcase
            end
            IT_LOAD: begin
                dec.reg_write_en = 1'b1;
                dec.alu_mux_en   = 1'b1;
                dec.mem_to_reg   = 1'b1;
                dec.read_mem     = 1'b1;
                dec.load_byte    = (funct3 == 3'b000);
                bad = !(funct3 == 3'b000 || funct3 == 3'b010);
            end
            IT_STORE: begin
                dec.alu_mux_en = 1'b1;
                dec.write_mem  = 1'b1;
                dec.store_byte = (funct3 == 3'b000);
                bad = !(funct3 == 3'b000 || funct3 == 3'b010);
            end
            IT_LUI: begin
                dec.reg_write_en = 1'b1;
                dec.alu_mux_en   = 1'b1;
                dec.alu_op       = FOP_LUI;
            end
            IT_AUIPC: begin
                dec.reg_write_en       = 1'b1;
                dec.alu_mux_en         = 1'b1;
                dec.pc_add_write_value = 1'b1;
            end
            IT_BRANCH: begin
                dec.alu_op = FOP_SUB;
                case (funct3)
                    3'b000: dec.branch_type = B_BEQ;
                    3'b001: dec.branch_type = B_BNE;
                    3'b100: dec.branch_type = B_BLT;
                    3'b101: dec.branch_type = B_BGE;
                    3'b110: begin dec.branch_type = B_BLTU; dec.u = 1'b1; end
                    3'b111: begin dec.branch_type = B_BGEU; dec.u = 1'b1; end
                    default: bad = 1'b1;
                endcase
            end
            IT_JAL: begin
                dec.branch_type  = B_JUMP;
                dec.reg_write_en = 1'b1;
                dec.read_next_pc = 1'b1;
            end
            IT_JALR: begin
                dec.branch_type  = B_JUMP;
                dec.reg_write_en = 1'b1;
                dec.read_next_pc = 1'b1;
                dec.alu_mux_en   = 1'b1;
                bad = (funct3 != 3'b000);
            end
            default: bad = 1'b1;
        endcase
    end

    assign bundle  = bad ? '0 : dec;
    assign illegal = bad;

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: registered, handshaked RV32I control stage.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to trap on undecodable words;
// otherwise they issue as NOP bundles and illegal_inst stays 0.
//   clk, rst (sync, active high)
//   instruction/inst_valid/inst_ready   fetch handshake
//   ctrl_valid/ctrl_ready + bundle      execute handshake (registered bundle)
//   mem_ack, branch_resolved, trap_ack  completion inputs
//   mem_timeout                         pulse in the last MEM_WAIT cycle
//   illegal_inst                        high while trapped
//
// state    | meaning
// RUN      | accepting/issuing bundles
// MEM_WAIT | issued load/store, waiting for mem_ack or timeout
// RESOLVE  | issued branch/jump, waiting for branch_resolved
// TRAP     | issued illegal word, waiting for trap_ack
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter  int MEM_TIMEOUT = 15,
    localparam int CNT_W       = $clog2(MEM_TIMEOUT + 1)
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic        ctrl_ready,
    output logic        ctrl_valid,
    output fop_t        alu_op,
    output b_t          branch_type,
    output logic        reg_write_en,
    output logic        alu_mux_en,
    output logic        store_byte,
    output logic        load_byte,
    output logic        mem_to_reg,
    output logic        pc_add_write_value,
    output logic        read_next_pc,
    output logic        write_mem,
    output logic        read_mem,
    output logic        slt,
    output logic        u,
    input  logic        mem_ack,
    input  logic        branch_resolved,
    output logic        mem_timeout,
    output logic        illegal_inst,
    input  logic        trap_ack
);

    seq_state_t       state;
    ctrl_bundle_t     bundle_q;
    ctrl_bundle_t     dec_bundle;
    logic             dec_illegal;
    logic             valid_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;
    logic             handshake;
    logic             mem_expire;
    logic             unused_operand_bits;

    control_decode u_decode (
        .key     ({instruction[31:25], instruction[14:12], instruction[6:0]}),
        .bundle  (dec_bundle),
        .illegal (dec_illegal)
    );

    assign unused_operand_bits = ^{instruction[24:15], instruction[11:7]};

    // A bundle accepted in the same cycle a mem/branch bundle drains is held
    // back from execute until the sequencer returns to RUN.
    assign ctrl_valid = valid_q && (state == RUN);
    assign inst_ready = (state == RUN) && (!valid_q || ctrl_ready);
    assign accept     = inst_valid && inst_ready;
    assign handshake  = ctrl_valid && ctrl_ready;
    // Expiry is decided in the last waiting cycle so a coincident ack wins.
    assign mem_expire = (state == MEM_WAIT) && !mem_ack &&
                        (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
    assign mem_timeout = mem_expire;

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;
    logic trap_flag;
    assign illegal_inst = trap_flag;
`else
    logic unused_illegal;
    assign unused_illegal = dec_illegal;
    assign illegal_inst   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            valid_q  <= 1'b0;
            bundle_q <= '0;
            wait_cnt <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
            trap_flag <= 1'b0;
`endif
        end else begin
            if (accept) begin
                bundle_q <= dec_bundle;
                valid_q  <= 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
                illegal_q <= dec_illegal;
`endif
            end else if (handshake) begin
                valid_q <= 1'b0;
            end

            case (state)
                RUN: begin
                    if (handshake) begin
                        if (bundle_q.read_mem || bundle_q.write_mem) begin
                            state    <= MEM_WAIT;
                            wait_cnt <= '0;
                        end else if (bundle_q.branch_type != B_NONE) begin
                            state <= RESOLVE;
                        end
`ifdef CTRL_ILLEGAL_TRAP_EN
                        else if (illegal_q) begin
                            state     <= TRAP;
                            trap_flag <= 1'b1;
                        end
`endif
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack || mem_expire) state <= RUN;
                    else wait_cnt <= wait_cnt + CNT_W'(1);
                end
                RESOLVE: begin
                    if (branch_resolved) state <= RUN;
                end
                TRAP: begin
                    if (trap_ack) begin
                        state <= RUN;
`ifdef CTRL_ILLEGAL_TRAP_EN
                        trap_flag <= 1'b0;
`endif
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign alu_op             = bundle_q.alu_op;
    assign branch_type        = bundle_q.branch_type;
    assign reg_write_en       = bundle_q.reg_write_en;
    assign alu_mux_en         = bundle_q.alu_mux_en;
    assign store_byte         = bundle_q.store_byte;
    assign load_byte          = bundle_q.load_byte;
    assign mem_to_reg         = bundle_q.mem_to_reg;
    assign pc_add_write_value = bundle_q.pc_add_write_value;
    assign read_next_pc       = bundle_q.read_next_pc;
    assign write_mem          = bundle_q.write_mem;
    assign read_mem           = bundle_q.read_mem;
    assign slt                = bundle_q.slt;
    assign u                  = bundle_q.u;

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: directed scenarios followed by randomized
// transactions checked against a table-driven instruction model.
module tb_control_sequencer;
    import ctrl_pkg::*;

    localparam int MEM_TIMEOUT = 15;

    // Flag positions inside the expected 11-bit flag field.
    localparam logic [10:0] F_RW   = 11'b100_0000_0000;
    localparam logic [10:0] F_AMUX = 11'b010_0000_0000;
    localparam logic [10:0] F_SB   = 11'b001_0000_0000;
    localparam logic [10:0] F_LB   = 11'b000_1000_0000;
    localparam logic [10:0] F_M2R  = 11'b000_0100_0000;
    localparam logic [10:0] F_PCA  = 11'b000_0010_0000;
    localparam logic [10:0] F_RNPC = 11'b000_0001_0000;
    localparam logic [10:0] F_WM   = 11'b000_0000_1000;
    localparam logic [10:0] F_RM   = 11'b000_0000_0100;
    localparam logic [10:0] F_SLT  = 11'b000_0000_0010;
    localparam logic [10:0] F_U    = 11'b000_0000_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic        inst_valid, inst_ready, ctrl_ready, ctrl_valid;
    fop_t        alu_op;
    b_t          branch_type;
    logic        reg_write_en, alu_mux_en, store_byte, load_byte, mem_to_reg;
    logic        pc_add_write_value, read_next_pc, write_mem, read_mem, slt, u;
    logic        mem_ack, branch_resolved, mem_timeout, illegal_inst, trap_ack;
    logic [17:0] obs;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        bit          f3c;
        logic [6:0]  f7;
        bit          f7c;
        logic [17:0] res;
    } ent_t;
    ent_t tbl[$];

    logic [31:0] stream [5] = '{32'h00108093, 32'h402081B3, 32'h0020C233,
                                32'h00209293, 32'h0020F333};

    always #5 clk = ~clk;

    control_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .ctrl_ready(ctrl_ready), .ctrl_valid(ctrl_valid),
        .alu_op(alu_op), .branch_type(branch_type), .reg_write_en(reg_write_en),
        .alu_mux_en(alu_mux_en), .store_byte(store_byte), .load_byte(load_byte),
        .mem_to_reg(mem_to_reg), .pc_add_write_value(pc_add_write_value),
        .read_next_pc(read_next_pc), .write_mem(write_mem), .read_mem(read_mem),
        .slt(slt), .u(u), .mem_ack(mem_ack), .branch_resolved(branch_resolved),
        .mem_timeout(mem_timeout), .illegal_inst(illegal_inst), .trap_ack(trap_ack)
    );

    assign obs = {alu_op, branch_type, reg_write_en, alu_mux_en, store_byte, load_byte,
                  mem_to_reg, pc_add_write_value, read_next_pc, write_mem, read_mem, slt, u};

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ent(input logic [6:0] op, input logic [2:0] f3, input bit f3c,
                       input logic [6:0] f7, input bit f7c, input logic [3:0] alu,
                       input logic [2:0] br, input logic [10:0] fl);
        ent_t e;
        e.op = op; e.f3 = f3; e.f3c = f3c; e.f7 = f7; e.f7c = f7c;
        e.res = {alu, br, fl};
        tbl.push_back(e);
    endtask

    task automatic build_table();
        // R-type
        ent(OP_R, 3'd0, 1, F7_BASE, 1, FOP_ADD, B_NONE, F_RW);
        ent(OP_R, 3'd0, 1, F7_ALT,  1, FOP_SUB, B_NONE, F_RW);
        ent(OP_R, 3'd1, 1, F7_BASE, 1, FOP_SLL, B_NONE, F_RW);
        ent(OP_R, 3'd2, 1, F7_BASE, 1, FOP_SLT, B_NONE, F_RW | F_SLT);
        ent(OP_R, 3'd3, 1, F7_BASE, 1, FOP_SLT, B_NONE, F_RW | F_SLT | F_U);
        ent(OP_R, 3'd4, 1, F7_BASE, 1, FOP_XOR, B_NONE, F_RW);
        ent(OP_R, 3'd5, 1, F7_BASE, 1, FOP_SRL, B_NONE, F_RW);
        ent(OP_R, 3'd5, 1, F7_ALT,  1, FOP_SRA, B_NONE, F_RW);
        ent(OP_R, 3'd6, 1, F7_BASE, 1, FOP_OR,  B_NONE, F_RW);
        ent(OP_R, 3'd7, 1, F7_BASE, 1, FOP_AND, B_NONE, F_RW);
        // loads / stores
        ent(OP_LOAD,  3'd0, 1, 7'd0, 0, FOP_ADD, B_NONE, F_RW | F_AMUX | F_LB | F_M2R | F_RM);
        ent(OP_LOAD,  3'd2, 1, 7'd0, 0, FOP_ADD, B_NONE, F_RW | F_AMUX | F_M2R | F_RM);
        ent(OP_STORE, 3'd0, 1, 7'd0, 0, FOP_ADD, B_NONE, F_AMUX | F_SB | F_WM);
        ent(OP_STORE, 3'd2, 1, 7'd0, 0, FOP_ADD, B_NONE, F_AMUX | F_WM);
        // I-type ALU
        ent(OP_IMM, 3'd0, 1, 7'd0,    0, FOP_ADD, B_NONE, F_RW | F_AMUX);
        ent(OP_IMM, 3'd2, 1, 7'd0,    0, FOP_SLT, B_NONE, F_RW | F_AMUX | F_SLT);
        ent(OP_IMM, 3'd3, 1, 7'd0,    0, FOP_SLT, B_NONE, F_RW | F_AMUX | F_SLT | F_U);
        ent(OP_IMM, 3'd4, 1, 7'd0,    0, FOP_XOR, B_NONE, F_RW | F_AMUX);
        ent(OP_IMM, 3'd6, 1, 7'd0,    0, FOP_OR,  B_NONE, F_RW | F_AMUX);
        ent(OP_IMM, 3'd7, 1, 7'd0,    0, FOP_AND, B_NONE, F_RW | F_AMUX);
        ent(OP_IMM, 3'd1, 1, F7_BASE, 1, FOP_SLL, B_NONE, F_RW | F_AMUX);
        ent(OP_IMM, 3'd5, 1, F7_BASE, 1, FOP_SRL, B_NONE, F_RW | F_AMUX);
        ent(OP_IMM, 3'd5, 1, F7_ALT,  1, FOP_SRA, B_NONE, F_RW | F_AMUX);
        // upper immediates
        ent(OP_LUI,   3'd0, 0, 7'd0, 0, FOP_LUI, B_NONE, F_RW | F_AMUX);
        ent(OP_AUIPC, 3'd0, 0, 7'd0, 0, FOP_ADD, B_NONE, F_RW | F_AMUX | F_PCA);
        // branches and jumps
        ent(OP_BRANCH, 3'd0, 1, 7'd0, 0, FOP_SUB, B_BEQ,  11'd0);
        ent(OP_BRANCH, 3'd1, 1, 7'd0, 0, FOP_SUB, B_BNE,  11'd0);
        ent(OP_BRANCH, 3'd4, 1, 7'd0, 0, FOP_SUB, B_BLT,  11'd0);
        ent(OP_BRANCH, 3'd5, 1, 7'd0, 0, FOP_SUB, B_BGE,  11'd0);
        ent(OP_BRANCH, 3'd6, 1, 7'd0, 0, FOP_SUB, B_BLTU, F_U);
        ent(OP_BRANCH, 3'd7, 1, 7'd0, 0, FOP_SUB, B_BGEU, F_U);
        ent(OP_JAL,  3'd0, 0, 7'd0, 0, FOP_ADD, B_JUMP, F_RW | F_RNPC);
        ent(OP_JALR, 3'd0, 1, 7'd0, 0, FOP_ADD, B_JUMP, F_RW | F_AMUX | F_RNPC);
    endtask

    // {illegal, alu_op, branch_type, flags}; illegal words map to an all-zero bundle.
    function automatic logic [18:0] ref_decode(input logic [31:0] w);
        foreach (tbl[i]) begin
            if (tbl[i].op == w[6:0] &&
                (!tbl[i].f3c || tbl[i].f3 == w[14:12]) &&
                (!tbl[i].f7c || tbl[i].f7 == w[31:25]))
                return {1'b0, tbl[i].res};
        end
        return {1'b1, 18'd0};
    endfunction

    task automatic check_idle(input string tag);
        #1;
        chk({tag, "_valid"}, ctrl_valid, 0);
        chk({tag, "_bundle"}, obs, 0);
        chk({tag, "_timeout"}, mem_timeout, 0);
        chk({tag, "_illegal"}, illegal_inst, 0);
        chk({tag, "_ready"}, inst_ready, 1);
    endtask

    // One instruction end to end: accept, optional backpressure, handshake,
    // then the wait phase its class implies, finishing back in RUN.
    task automatic run_txn(input logic [31:0] w, input int hold, input int delay,
                           input bit early_ack);
        logic [18:0] r;
        int          last;
        bit          is_mem, is_br;
        r      = ref_decode(w);
        is_mem = r[3] | r[2];
        is_br  = (r[13:11] != 3'd0);
        instruction = w; inst_valid = 1'b1; ctrl_ready = 1'b0;
        #1 chk("ready_idle", inst_ready, 1);
        tick();
        inst_valid = 1'b0; instruction = $urandom;
        #1;
        chk("valid_n1", ctrl_valid, 1);
        chk("bundle", obs, r[17:0]);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("bundle_held", obs, r[17:0]);
            chk("ready_bp", inst_ready, 0);
        end
        // Completion inputs during the handshake cycle must be ignored.
        ctrl_ready = 1'b1; mem_ack = early_ack; branch_resolved = early_ack; trap_ack = early_ack;
        #1 chk("ready_hs", inst_ready, 1);
        tick();
        ctrl_ready = 1'b0; mem_ack = 1'b0; branch_resolved = 1'b0; trap_ack = 1'b0;
        if (is_mem) begin
            last = (delay < MEM_TIMEOUT) ? delay : MEM_TIMEOUT;
            for (int k = 1; k <= last; k++) begin
                mem_ack = (k == delay);
                #1;
                chk("mem_stall", inst_ready, 0);
                chk("mem_timeout", mem_timeout, (k == MEM_TIMEOUT) && (delay > MEM_TIMEOUT));
                tick();
            end
            mem_ack = 1'b0;
        end else if (is_br) begin
            for (int k = 1; k <= delay; k++) begin
                branch_resolved = (k == delay);
                mem_ack = 1'($urandom_range(0, 1));
                #1;
                chk("br_stall", inst_ready, 0);
                chk("br_timeout", mem_timeout, 0);
                tick();
            end
            branch_resolved = 1'b0; mem_ack = 1'b0;
        end else if (r[18]) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            for (int k = 1; k <= delay; k++) begin
                trap_ack = (k == delay);
                #1;
                chk("trap_flag", illegal_inst, 1);
                chk("trap_stall", inst_ready, 0);
                tick();
            end
            trap_ack = 1'b0;
`endif
        end
        #1;
        chk("ready_after", inst_ready, 1);
        chk("valid_after", ctrl_valid, 0);
        chk("illegal_after", illegal_inst, 0);
        chk("timeout_after", mem_timeout, 0);
    endtask

    initial begin
        logic [31:0] w;
        int          e;
        build_table();
        rst = 1'b1; instruction = '0; inst_valid = 1'b0; ctrl_ready = 1'b0;
        mem_ack = 1'b0; branch_resolved = 1'b0; trap_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_idle("reset");

        // addi x1,x0,0x7FF
        run_txn(32'h7FF00093, 0, 1, 0);
        chk("addi_const", ref_decode(32'h7FF00093), {1'b0, FOP_ADD, B_NONE, F_RW | F_AMUX});

        // add then sub under 3 cycles of backpressure
        instruction = 32'h002081B3; inst_valid = 1'b1; ctrl_ready = 1'b0;
        tick();
        instruction = 32'h402081B3;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_add_held", obs, ref_decode(32'h002081B3));
            chk("bp_ready", inst_ready, 0);
            tick();
        end
        ctrl_ready = 1'b1;
        #1 chk("bp_drain_ready", inst_ready, 1);
        tick();
        inst_valid = 1'b0;
        #1;
        chk("bp_sub", obs, ref_decode(32'h402081B3));
        chk("bp_sub_valid", ctrl_valid, 1);
        tick();
        ctrl_ready = 1'b0;
        #1 chk("bp_empty", ctrl_valid, 0);

        // back-to-back stream, one per cycle
        ctrl_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            instruction = stream[i]; inst_valid = 1'b1;
            #1 chk("stream_ready", inst_ready, 1);
            tick();
            chk("stream_bundle", obs, ref_decode(stream[i]));
        end
        inst_valid = 1'b0;
        tick();
        ctrl_ready = 1'b0;
        #1 chk("stream_empty", ctrl_valid, 0);

        run_txn(32'h0000A083, 0, 4, 1);                // lw, ack 4 cycles after handshake
        run_txn(32'h0020A023, 1, MEM_TIMEOUT + 3, 0);  // sw, timeout
        run_txn(32'h0020A023, 0, MEM_TIMEOUT, 0);      // ack coincides with expiry
        run_txn(32'h00208463, 2, 3, 1);                // beq
        run_txn(32'hFFFFFFFF, 0, 2, 1);                // illegal word

        // reset while waiting on memory
        instruction = 32'h0000A083; inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0; ctrl_ready = 1'b1;
        tick();
        ctrl_ready = 1'b0;
        tick();
        chk("rst_mem_stall", inst_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rst_mem");

`ifdef CTRL_ILLEGAL_TRAP_EN
        // reset while trapped
        instruction = 32'hFFFFFFFF; inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0; ctrl_ready = 1'b1;
        tick();
        ctrl_ready = 1'b0;
        #1 chk("rst_trap_flag", illegal_inst, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rst_trap");
`endif

        for (int n = 0; n < 150; n++) begin
            w = $urandom;
            if ($urandom_range(0, 5) != 0) begin
                e = int'($urandom_range(0, tbl.size() - 1));
                w[6:0] = tbl[e].op;
                if (tbl[e].f3c) w[14:12] = tbl[e].f3;
                if (tbl[e].f7c) w[31:25] = tbl[e].f7;
            end
            run_txn(w, int'($urandom_range(0, 2)), int'($urandom_range(1, MEM_TIMEOUT + 2)),
                    1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
